// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed 4-digit seven-segment scan driver with frame-aligned commit
// Optional feature macro: LEADING_ZERO_BLANK_EN (auto-blank leading zero digits)
module seg_scan_driver #(
    parameter int DIGIT_TICKS = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    output logic        ready,
    input  logic [3:0]  blank,
    input  logic [3:0]  dp_mask,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);
    localparam int CW = $clog2(DIGIT_TICKS);
    localparam logic [CW-1:0] TC_VAL = CW'(DIGIT_TICKS - 1);

    logic [CW-1:0] tick_q, tick_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   pend_val_q, pend_val_d;
    logic          pend_q, pend_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;

    logic          tc;
    logic          boundary;
    logic [3:0]    nib;
    logic          auto_blank;
    logic          digit_off;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    // Commit precedes capture so a load on a boundary with a word still pending is dropped.
    always_comb begin
        tc         = (tick_q == TC_VAL);
        boundary   = tc && (idx_q == 2'd3);
        tick_d     = tc ? '0 : tick_q + 1'b1;
        idx_d      = tc ? idx_q + 2'd1 : idx_q;
        disp_d     = disp_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        if (boundary && pend_q) begin
            disp_d = pend_val_q;
            pend_d = 1'b0;
        end
        if (load && !pend_q) begin
            pend_val_d = value;
            pend_d     = 1'b1;
        end
    end

    always_comb begin
        nib = disp_q[{idx_q, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        case (idx_q)
            2'd1:    auto_blank = (disp_q[15:4] == 12'h000);
            2'd2:    auto_blank = (disp_q[15:8] == 8'h00);
            2'd3:    auto_blank = (disp_q[15:12] == 4'h0);
            default: auto_blank = 1'b0;
        endcase
`else
        auto_blank = 1'b0;
`endif
        digit_off = blank[idx_q] | auto_blank;
        an_d      = digit_off ? 4'hF : ~(4'b0001 << idx_q);
        seg_d     = digit_off ? 7'h7F : decode(nib);
        dp_d      = digit_off | ~dp_mask[idx_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q     <= '0;
            idx_q      <= 2'd0;
            disp_q     <= 16'h0000;
            pend_val_q <= 16'h0000;
            pend_q     <= 1'b0;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
            an_q       <= 4'hF;
        end else begin
            tick_q     <= tick_d;
            idx_q      <= idx_d;
            disp_q     <= disp_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign ready      = ~pend_q;
    assign frame_done = boundary;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
endmodule
